write_back: RTL
===============

Name: write_back

Overview:
- Final pipeline stage; consumes the MEM/WB outputs of the memory stage.
- Registers the retiring instruction, formats load data (byte/half/word, signed/unsigned), selects the write-back value (ALU result, load data or link address), and drives the register-file write port.
- Owns the halt sequence: a halt retiring here drains younger instructions, then freezes the pipeline tail and flags the debug unit.
- Counts retired instructions for the debug unit.

Parameters:
- N_BITS, 32, datapath width
- N_BITS_REG, 5, register index width
- DRAIN_CYCLES, 3, advances squashed after a halt retires (range 1-15)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous active-low reset
- i_valid  in  1  pipeline enable
- i_exec_mode  in  1  0 = continuous, 1 = step mode
- i_step  in  1  single-step pulse, used only when i_exec_mode = 1
- i_mem_to_reg  in  1  1 = write load data
- i_reg_write  in  1  register write request
- i_halt  in  1  instruction is HALT
- i_jump  in  2  00 none, 01 jump, 10 jump-and-link, 11 reserved (treated as 00)
- i_pc_4  in  N_BITS  link address
- i_read_data  in  N_BITS  raw memory word
- i_alu_result  in  N_BITS  ALU result / load address
- i_rt_rd  in  N_BITS_REG  destination register
- i_load_size  in  2  00 byte, 01 half, 1x word
- i_load_unsigned  in  1  zero-extend when 1
- o_reg_write  out  1  register-file write enable
- o_write_reg  out  N_BITS_REG  register-file write address
- o_write_data  out  N_BITS  register-file write data
- o_halted  out  1  pipeline halted
- o_retired_count  out  N_BITS  retired-instruction count

Behaviour:
- adv = i_valid && (!i_exec_mode || i_step) && state != HALTED.
- All outputs are registered; latency is 1 rising edge from input capture.
- When adv = 0, all outputs and the state hold.
- Reset (i_reset = 0, async): every output is 0, state = RUN, drain counter = 0. Reset mid-drain or while HALTED returns to RUN immediately.
- Load formatting, little-endian, addr = i_alu_result[1:0]:
  - byte: lane addr
  - half: lane addr[1] (addr[0] ignored)
  - word: full word
  - sign-extend unless i_load_unsigned = 1
- Write-data select, in priority order:
  - i_jump = 10 → i_pc_4
  - else i_mem_to_reg → formatted load data
  - else i_alu_result
- o_reg_write = i_reg_write or (i_jump = 10), forced 0 when i_rt_rd = 0.
- o_write_reg = i_rt_rd.
- FSM:
  - RUN: on adv, capture normally.
    - If i_halt = 1: the halt itself writes nothing (o_reg_write = 0), counter loads DRAIN_CYCLES, go to DRAIN.
  - DRAIN: on each adv, capture with o_reg_write forced 0 (younger instructions squashed); counter decrements.
    - When an adv finds counter = 1: go to HALTED and set o_halted = 1 on that edge.
    - i_halt seen during DRAIN is ignored.
  - HALTED: o_halted = 1; o_reg_write = 0; nothing captured; only reset exits.
- Retire count:
  - Increments by 1 on each adv in RUN, including the halt instruction.
  - Does not increment in DRAIN or HALTED.
  - Wraps at 2^N_BITS - 1 → 0.
- Step mode: exactly one capture per cycle with i_step = 1. A held i_step advances every cycle (edge detection is upstream).

Optional Feature:
- WB_RETIRE_CNT_EN defined: o_retired_count implemented as above.
- Not defined: counter logic omitted; o_retired_count tied to 0. All other behaviour unchanged.

Test Plan:
- Reset low mid-stream (state DRAIN) → all outputs 0, state RUN. Next adv with i_reg_write = 1, rt_rd = 5, alu = 0x1234 → o_reg_write = 1, o_write_reg = 5, o_write_data = 0x00001234.
- Loads, read_data = 0x80FF7F01, mem_to_reg = 1:
  - byte, addr 2, signed → 0xFFFFFFFF
  - byte, addr 1, unsigned → 0x0000007F
  - half, addr 3, signed → 0xFFFF80FF
  - word → 0x80FF7F01
- JAL: i_jump = 10, pc_4 = 0x40, rt_rd = 31, mem_to_reg = 1 → o_write_data = 0x40, o_reg_write = 1. Same with rt_rd = 0 → o_reg_write = 0.
- Halt with DRAIN_CYCLES = 3: halt, then 3 writing instructions, then a 4th →
  - no writes from the halt or the next 3
  - o_halted = 1 after the 3rd post-halt adv
  - 4th ignored; outputs frozen
  - count = instructions before halt + 1
- Step mode, i_exec_mode = 1: 5 cycles with i_step = 0 → outputs unchanged; one i_step pulse → exactly one capture, count +1.
- Counter wrap: preload via 2^N_BITS - 1 advances (or use a reduced N_BITS for the test), then one more retire → o_retired_count = 0. With WB_RETIRE_CNT_EN undefined, o_retired_count stays 0 throughout.

Source files
------------

// File: rtl/write_back_if.sv
// Memory-to-write-back bus: retiring-instruction inputs and register-file/debug outputs.
interface write_back_if #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5
);
  logic                  i_valid;
  logic                  i_exec_mode;
  logic                  i_step;
  logic                  i_mem_to_reg;
  logic                  i_reg_write;
  logic                  i_halt;
  logic [1:0]            i_jump;
  logic [N_BITS-1:0]     i_pc_4;
  logic [N_BITS-1:0]     i_read_data;
  logic [N_BITS-1:0]     i_alu_result;
  logic [N_BITS_REG-1:0] i_rt_rd;
  logic [1:0]            i_load_size;
  logic                  i_load_unsigned;
  logic                  o_reg_write;
  logic [N_BITS_REG-1:0] o_write_reg;
  logic [N_BITS-1:0]     o_write_data;
  logic                  o_halted;
  logic [N_BITS-1:0]     o_retired_count;

  modport master (
    output i_valid, i_exec_mode, i_step, i_mem_to_reg, i_reg_write, i_halt, i_jump,
           i_pc_4, i_read_data, i_alu_result, i_rt_rd, i_load_size, i_load_unsigned,
    input  o_reg_write, o_write_reg, o_write_data, o_halted, o_retired_count
  );

  modport slave (
    input  i_valid, i_exec_mode, i_step, i_mem_to_reg, i_reg_write, i_halt, i_jump,
           i_pc_4, i_read_data, i_alu_result, i_rt_rd, i_load_size, i_load_unsigned,
    output o_reg_write, o_write_reg, o_write_data, o_halted, o_retired_count
  );
endinterface

// File: rtl/write_back.sv
// Write-back stage: load formatting, write-data select, halt drain FSM, retire counter.
// Latency 1 edge; holds when not advancing. Retire counter enabled by WB_RETIRE_CNT_EN.
module write_back #(
  parameter int N_BITS       = 32,
  parameter int N_BITS_REG   = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  write_back_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                state_q;
  logic [3:0]            drain_q;
  logic                  reg_write_q;
  logic [N_BITS_REG-1:0] write_reg_q;
  logic [N_BITS-1:0]     write_data_q;
  logic                  halted_q;

  logic                  adv;
  logic [31:0]           rd32;
  logic [31:0]           byte_sh;
  logic [31:0]           half_sh;
  logic [N_BITS-1:0]     load_fmt;
  logic [N_BITS-1:0]     write_data_d;
  logic                  reg_write_d;

  assign adv = bus.i_valid && (!bus.i_exec_mode || bus.i_step) && (state_q != HALTED);

  // Lane extraction works on a 32-bit view so narrow datapaths still format correctly.
  always_comb begin
    rd32    = 32'(bus.i_read_data);
    byte_sh = rd32 >> {bus.i_alu_result[1:0], 3'b000};
    half_sh = rd32 >> {bus.i_alu_result[1], 4'b0000};
    load_fmt = bus.i_read_data;
    case (bus.i_load_size)
      2'b00: begin
        if (bus.i_load_unsigned) load_fmt = N_BITS'(byte_sh[7:0]);
        else                     load_fmt = N_BITS'($signed(byte_sh[7:0]));
      end
      2'b01: begin
        if (bus.i_load_unsigned) load_fmt = N_BITS'(half_sh[15:0]);
        else                     load_fmt = N_BITS'($signed(half_sh[15:0]));
      end
      default: load_fmt = bus.i_read_data;
    endcase
  end

  always_comb begin
    write_data_d = bus.i_alu_result;
    if (bus.i_jump == 2'b10)   write_data_d = bus.i_pc_4;
    else if (bus.i_mem_to_reg) write_data_d = load_fmt;
    reg_write_d = (bus.i_reg_write || (bus.i_jump == 2'b10)) && (bus.i_rt_rd != '0);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= RUN;
      drain_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      halted_q     <= 1'b0;
    end else if (adv) begin
      write_reg_q  <= bus.i_rt_rd;
      write_data_q <= write_data_d;
      case (state_q)
        RUN: begin
          reg_write_q <= reg_write_d && !bus.i_halt;
          if (bus.i_halt) begin
            drain_q <= 4'(DRAIN_CYCLES);
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          reg_write_q <= 1'b0;
          drain_q     <= drain_q - 4'd1;
          if (drain_q == 4'd1) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        default: reg_write_q <= 1'b0;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [N_BITS-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                   count_q <= '0;
    else if (adv && state_q == RUN) count_q <= count_q + N_BITS'(1);
  end

  assign bus.o_retired_count = count_q;
`else
  assign bus.o_retired_count = '0;
`endif

  assign bus.o_reg_write  = reg_write_q;
  assign bus.o_write_reg  = write_reg_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_halted     = halted_q;

endmodule
